bsg_cache_pkt_mem_responder: RTL and testbench

- Cache-side responder for the bsg_cache packet interface.
- Accepts bsg_cache_pkt_s requests from a cache-packet initiator, such as the manycore link-to-cache adapter, and executes them against a flop-based word memory.
- Returns one data word per request through a two-stage (tl/tv) pipeline, with a v_we pulse marking each tl->tv advance.
- Used as a drop-in cache model in link-adapter testbenches and in small non-cached scratch tiles.

---
 rtl/bsg_cache_pkg.sv | 37 +++
 rtl/bsg_cache_pkt_mem_responder_alu.sv | 58 +++++
 rtl/bsg_cache_pkt_mem_responder.sv | 122 ++++++++++++
 tb/tb_bsg_cache_pkt_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_pkg.sv
// Shared cache-packet definitions: opcode encoding and packet width helper.
// Packet layout, MSB first: {opcode, addr, data, mask}.
package bsg_cache_pkg;

    localparam int bsg_cache_opcode_width_gp = 6;
    localparam int byte_offset_width_lp      = 2;

    typedef enum logic [5:0] {
        TAGST     = 6'b000000,
        TAGFL     = 6'b000001,
        TAGLA     = 6'b000010,
        AFL       = 6'b000011,
        AFLINV    = 6'b000100,
        AINV      = 6'b000101,
        LB        = 6'b010000,
        LH        = 6'b010001,
        LW        = 6'b010010,
        LD        = 6'b010011,
        LBU       = 6'b010100,
        LHU       = 6'b010101,
        SB        = 6'b011000,
        SH        = 6'b011001,
        SW        = 6'b011010,
        SD        = 6'b011011,
        SM        = 6'b011100,
        AMOSWAP_W = 6'b100000,
        AMOADD_W  = 6'b100001,
        AMOXOR_W  = 6'b100010,
        AMOAND_W  = 6'b100011,
        AMOOR_W   = 6'b100100
    } bsg_cache_opcode_e;

    function automatic int bsg_cache_pkt_width(input int addr_width, input int data_width);
        return bsg_cache_opcode_width_gp + addr_width + data_width + (data_width / 8);
    endfunction

endpackage

// File: rtl/bsg_cache_pkt_mem_responder_alu.sv
// Combinational opcode execution: load extraction, store merge and AMO update
// of one 32-bit word.
module bsg_cache_pkt_mem_responder_alu
    import bsg_cache_pkg::*;
(
    input  bsg_cache_opcode_e i_opcode,
    input  logic [1:0]        i_byte_sel,
    input  logic [3:0]        i_mask,
    input  logic [31:0]       i_data,
    input  logic [31:0]       i_old,
    output logic [31:0]       o_result,
    output logic [31:0]       o_wdata,
    output logic              o_we,
    output logic              o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merge;

    // Sub-word extraction and byte-masked merge.
    always_comb begin
        case (i_byte_sel)
            2'd0:    w_byte = i_old[7:0];
            2'd1:    w_byte = i_old[15:8];
            2'd2:    w_byte = i_old[23:16];
            2'd3:    w_byte = i_old[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_byte_sel[1] ? i_old[31:16] : i_old[15:0];
        for (int i = 0; i < 4; i++) begin
            w_merge[8*i +: 8] = i_mask[i] ? i_data[8*i +: 8] : i_old[8*i +: 8];
        end
    end

    // Opcode decode: result word plus optional write-back.
    always_comb begin
        o_result  = 32'h0000_0000;
        o_wdata   = i_old;
        o_we      = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            LW:        o_result = i_old;
            LH:        o_result = {{16{w_half[15]}}, w_half};
            LHU:       o_result = {16'h0000, w_half};
            LB:        o_result = {{24{w_byte[7]}}, w_byte};
            LBU:       o_result = {24'h000000, w_byte};
            SW:        begin o_wdata = i_data;  o_we = 1'b1; end
            SM:        begin o_wdata = w_merge; o_we = 1'b1; end
            AMOSWAP_W: begin o_result = i_old; o_wdata = i_data;          o_we = 1'b1; end
            AMOOR_W:   begin o_result = i_old; o_wdata = i_old | i_data;  o_we = 1'b1; end
            AMOADD_W:  begin o_result = i_old; o_wdata = i_old + i_data;  o_we = 1'b1; end
            TAGST, TAGLA, TAGFL, AFL, AFLINV, AINV: o_result = 32'h0000_0000;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bsg_cache_pkt_mem_responder.sv
// Cache-packet responder: tl/tv two-stage pipeline in front of a flop-based
// word memory; the memory read-modify-write happens on the tl->tv advance.
module bsg_cache_pkt_mem_responder
    import bsg_cache_pkg::*;
#(
    parameter int addr_width_p       = 32,
    parameter int data_width_p       = 32,
    parameter int mem_els_p          = 1024,
    localparam int lg_mem_els_lp     = (mem_els_p > 1) ? $clog2(mem_els_p) : 1,
    localparam int cache_pkt_width_lp = bsg_cache_pkt_width(addr_width_p, data_width_p)
)(
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [cache_pkt_width_lp-1:0] cache_pkt_i,
    input  logic                          v_i,
    output logic                          yumi_o,
    output logic [data_width_p-1:0]       data_o,
    output logic                          v_o,
    input  logic                          yumi_i,
    output logic                          v_we_o
);

    localparam int mask_width_lp = data_width_p / 8;

    logic                          r_tl_v;
    logic                          r_tv_v;
    logic [cache_pkt_width_lp-1:0] r_tl_pkt;
    logic [data_width_p-1:0]       r_tv_data;
    logic [data_width_p-1:0]       r_mem [mem_els_p];

    logic                          w_tv_ready;
    logic                          w_tl_ready;
    logic                          w_v_we;
    logic                          w_yumi;
    bsg_cache_opcode_e             w_opcode;
    logic [addr_width_p-1:0]       w_addr;
    logic [data_width_p-1:0]       w_data;
    logic [mask_width_lp-1:0]      w_mask;
    logic [lg_mem_els_lp-1:0]      w_idx;
    logic [data_width_p-1:0]       w_result;
    logic [data_width_p-1:0]       w_wdata;
    logic                          w_we;
    logic                          w_illegal;
    logic                          w_unused_addr;

    assign w_opcode = bsg_cache_opcode_e'(r_tl_pkt[cache_pkt_width_lp-1 -: bsg_cache_opcode_width_gp]);
    assign w_addr   = r_tl_pkt[mask_width_lp + data_width_p +: addr_width_p];
    assign w_data   = r_tl_pkt[mask_width_lp +: data_width_p];
    assign w_mask   = r_tl_pkt[mask_width_lp-1:0];
    // Upper address bits alias onto the same word.
    assign w_idx         = w_addr[byte_offset_width_lp +: lg_mem_els_lp];
    assign w_unused_addr = ^w_addr[addr_width_p-1:byte_offset_width_lp+lg_mem_els_lp];

    // Handshakes are gated by reset so nothing is accepted or written while it is held.
    assign w_tv_ready = ~r_tv_v | yumi_i;
    assign w_v_we     = reset_n_i & r_tl_v & w_tv_ready;
    assign w_tl_ready = ~r_tl_v | w_v_we;
    assign w_yumi     = reset_n_i & v_i & w_tl_ready;

    assign yumi_o = w_yumi;
    assign v_we_o = w_v_we;
    assign v_o    = r_tv_v;
    assign data_o = r_tv_data;

    bsg_cache_pkt_mem_responder_alu u_alu (
        .i_opcode   (w_opcode),
        .i_byte_sel (w_addr[1:0]),
        .i_mask     (w_mask),
        .i_data     (w_data),
        .i_old      (r_mem[w_idx]),
        .o_result   (w_result),
        .o_wdata    (w_wdata),
        .o_we       (w_we),
        .o_illegal  (w_illegal)
    );

    // Pipeline valid bits and response data.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_tl_v    <= 1'b0;
            r_tv_v    <= 1'b0;
            r_tv_data <= '0;
        end else begin
            if (w_yumi) begin
                r_tl_v <= 1'b1;
            end else if (w_v_we) begin
                r_tl_v <= 1'b0;
            end
            if (w_v_we) begin
                r_tv_v    <= 1'b1;
                r_tv_data <= w_result;
            end else if (yumi_i) begin
                r_tv_v <= 1'b0;
            end
        end
    end

    // Captured request packet; no reset needed since r_tl_v qualifies it.
    always_ff @(posedge clk_i) begin
        if (w_yumi) begin
            r_tl_pkt <= cache_pkt_i;
        end
    end

    // Word memory, written only on the tl->tv advance.
    always_ff @(posedge clk_i) begin
        if (w_v_we && w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

`ifndef SYNTHESIS
    // Flags unsupported opcodes as they execute.
    always_ff @(posedge clk_i) begin
        if (w_v_we && w_illegal) begin
            $error("bsg_cache_pkt_mem_responder: unsupported opcode %h (addr parity %b)",
                   w_opcode, w_unused_addr);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_cache_pkt_mem_responder.sv
// Scoreboard bench: driver pushes reference-model results at accept time, a
// monitor pops and compares every consumed response.
module tb_bsg_cache_pkt_mem_responder;
    import bsg_cache_pkg::*;

    localparam int AW = 32;
    localparam int PW = bsg_cache_pkt_width(AW, 32);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [PW-1:0] pkt;
    logic          v_i;
    logic          yumi_o;
    logic [31:0]   data_o;
    logic          v_o;
    logic          yumi_i = 1'b0;
    logic          v_we_o;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [0:1023];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          yumi_mode = 0;
    bit          lat_chk = 1'b0;

    bsg_cache_pkt_mem_responder #(.addr_width_p(AW), .data_width_p(32), .mem_els_p(1024)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .cache_pkt_i(pkt), .v_i(v_i), .yumi_o(yumi_o),
        .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .v_we_o(v_we_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one request against the model memory.
    task automatic model(input bsg_cache_opcode_e op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask,
                         output logic [31:0] res);
        int          idx = int'(addr[11:2]);
        logic [31:0] old = mem_m[idx];
        logic [31:0] b   = (old >> (8 * addr[1:0])) & 32'h0000_00FF;
        logic [31:0] h   = (old >> (16 * addr[1])) & 32'h0000_FFFF;
        logic [31:0] nw  = old;
        res = 32'd0;
        case (op)
            LW:        res = old;
            LBU:       res = b;
            LB:        res = (b >= 32'd128) ? b - 32'd256 : b;
            LHU:       res = h;
            LH:        res = (h >= 32'd32768) ? h - 32'd65536 : h;
            SW:        mem_m[idx] = data;
            SM: begin
                for (int i = 0; i < 4; i++) begin
                    if (mask[i]) nw = (nw & ~(32'hFF << (8 * i))) | (data & (32'hFF << (8 * i)));
                end
                mem_m[idx] = nw;
            end
            AMOSWAP_W: begin res = old; mem_m[idx] = data; end
            AMOOR_W:   begin res = old; mem_m[idx] = old | data; end
            AMOADD_W:  begin res = old; mem_m[idx] = old + data; end
            default:   res = 32'd0;
        endcase
    endtask

    task automatic record(input bsg_cache_opcode_e op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] r;
        model(op, addr, data, mask, r);
        sb.push_back('{data: r, cyc: cyc, chk: lat_chk});
    endtask

    task automatic send(input bsg_cache_opcode_e op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask, output int waits);
        @(negedge clk);
        v_i = 1'b1;
        pkt = {op, addr, data, mask};
        #4;
        waits = 0;
        while (!yumi_o && waits < 200) begin
            @(negedge clk);
            #4;
            waits++;
        end
        if (yumi_o) begin
            record(op, addr, data, mask);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: op %h addr %h never accepted", op, addr);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
        end
    endtask

    // Monitor: consumes responses (per yumi_mode) and checks them in order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (yumi_mode)
                0:       yumi_i = 1'b0;
                1:       yumi_i = v_o;
                default: yumi_i = v_o & 1'($urandom_range(0, 1));
            endcase
            #4;
            if (reset_n && v_o && yumi_i) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_resp: got %h, expected no response", data_o);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", data_o, e.data);
                    if (e.chk) check("resp_latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                w;
        int                acc;
        int                we;
        int                k;
        logic [31:0]       saved;
        logic [31:0]       bp_addr [4];
        bsg_cache_opcode_e ops [11];
        bp_addr = '{32'h10, 32'h20, 32'h30, 32'h10};
        ops = '{LW, LH, LHU, LB, LBU, SW, SM, AMOSWAP_W, AMOOR_W, AMOADD_W, TAGST};

        // Reset with a request pending: nothing is accepted while reset is held.
        reset_n   = 1'b0;
        v_i       = 1'b1;
        pkt       = {SW, 32'h10, 32'hDEAD_BEEF, 4'hF};
        yumi_mode = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #4;
            check("reset_outputs", {29'd0, yumi_o, v_o, v_we_o}, 32'd0);
            if (i == 0) check("reset_data", data_o, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #4;
        check("first_accept", {31'd0, yumi_o}, 32'd1);
        if (yumi_o) record(SW, 32'h10, 32'hDEAD_BEEF, 4'hF);

        // Loads of every width after a store.
        send(LW,  32'h10, 32'd0, 4'h0, w);
        send(LB,  32'h13, 32'd0, 4'h0, w);
        send(LBU, 32'h13, 32'd0, 4'h0, w);
        send(LH,  32'h12, 32'd0, 4'h0, w);
        send(LHU, 32'h12, 32'd0, 4'h0, w);
        // Masked store.
        send(SW,  32'h20, 32'hAABB_CCDD, 4'hF, w);
        send(SM,  32'h20, 32'h1122_3344, 4'b0101, w);
        send(LW,  32'h20, 32'd0, 4'h0, w);
        // Atomics, including add wrap-around.
        send(SW,        32'h30, 32'hFFFF_FFFF, 4'hF, w);
        send(AMOADD_W,  32'h30, 32'd2, 4'hF, w);
        send(LW,        32'h30, 32'd0, 4'h0, w);
        send(AMOOR_W,   32'h30, 32'h10, 4'hF, w);
        send(LW,        32'h30, 32'd0, 4'h0, w);
        send(AMOSWAP_W, 32'h30, 32'd7, 4'hF, w);
        send(LW,        32'h30, 32'd0, 4'h0, w);
        idle();
        drain();

        // Backpressure: two accepts fill tl and tv, then everything stalls.
        yumi_mode = 0;
        acc = 0;
        we  = 0;
        k   = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            v_i = 1'b1;
            pkt = {LW, bp_addr[k], 32'd0, 4'h0};
            #4;
            if (v_we_o) we++;
            if (yumi_o) begin
                record(LW, bp_addr[k], 32'd0, 4'h0);
                k++;
                acc++;
            end
        end
        check("bp_accepts", 32'(acc), 32'd2);
        check("bp_v_we", 32'(we), 32'd1);
        check("bp_hold_data", data_o, sb[0].data);
        yumi_mode = 1;
        while (k < 4) begin
            send(LW, bp_addr[k], 32'd0, 4'h0, w);
            k++;
        end
        idle();
        drain();

        // Randomized traffic with random consumer stalls and aliased high address bits.
        for (int i = 64; i < 80; i++) send(SW, 32'(i * 4), $urandom, 4'hF, w);
        yumi_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send(ops[$urandom_range(0, 10)],
                 {12'($urandom), 10'($urandom_range(64, 79)), 2'($urandom)},
                 $urandom, 4'($urandom), w);
        end
        idle();
        drain();

        // Streaming: one accept per cycle, fixed two-cycle latency.
        yumi_mode = 1;
        lat_chk   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send((i % 3 == 1) ? AMOADD_W : LW, 32'(256 + 4 * (i % 4)), 32'(i + 1), 4'hF, w);
            check("stream_waits", 32'(w), 32'd0);
        end
        idle();
        drain();
        lat_chk = 1'b0;

        // Reset with tl and tv full: the store sitting in tl must be dropped.
        yumi_mode = 0;
        saved = mem_m[4];
        send(LW, 32'h20, 32'd0, 4'h0, w);
        send(SW, 32'h10, 32'h1234_5678, 4'hF, w);
        @(negedge clk);
        v_i     = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #4;
        check("reset_drop_vo", {31'd0, v_o}, 32'd0);
        sb.delete();
        mem_m[4] = saved;
        @(negedge clk);
        reset_n   = 1'b1;
        yumi_mode = 1;
        send(LW, 32'h10, 32'd0, 4'h0, w);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
